fir_out_quantizer: RTL and testbench
====================================

FIR_OUT_QUANTIZER -- requirements
Module: fir_out_quantizer

Interface
REQ-001 Parameter IN_WIDTH, default 37, SHALL be the signed width of the incoming FIR result (2*16 + clog2(29)).
REQ-002 Parameter OUT_WIDTH, default 16, SHALL be the signed width of the quantized output sample.
REQ-003 Parameter SHIFT_WIDTH, default 5, SHALL be the width of the shift control; 2^SHIFT_WIDTH-1 < IN_WIDTH is a legal-configuration requirement.
REQ-004 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 Port arst, input, 1: reset, asynchronous assert, active-high.
REQ-006 Port shift, input, SHIFT_WIDTH: right-shift amount, unsigned.
REQ-007 Port sat_clr, input, 1: synchronous clear of the saturation counter and flag.
REQ-008 Port src_data_in, input, IN_WIDTH signed: FIR result.
REQ-009 Port src_valid_in, input, 1: src_data_in valid.
REQ-010 Port src_ready_out, output, 1: block can accept; driven directly from a flop.
REQ-011 Port dst_data_out, output, OUT_WIDTH signed: quantized sample.
REQ-012 Port dst_valid_out, output, 1: dst_data_out valid.
REQ-013 Port dst_ready_in, input, 1: consumer ready.
REQ-014 Port sat_count, output, 16: number of saturated samples accepted.
REQ-015 Port sat_flag, output, 1: sticky, set on any saturation.

Function
REQ-016 A transfer SHALL occur on a side only when valid and ready are both high at a rising clk edge.
REQ-017 shift SHALL be sampled with the input word at acceptance; changing shift SHALL NOT affect words already accepted.
REQ-018 Rounding SHALL be round-half-up: add 2^(shift-1) when shift>0 (nothing when shift=0), then arithmetic right shift by shift, in IN_WIDTH+1 bits so the addition cannot overflow.
REQ-019 The result SHALL saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1], i.e. [-32768, 32767] by default.
REQ-020 Latency SHALL be exactly 1 cycle: a word accepted at edge N is presented with dst_valid_out high after edge N when the output is empty.
REQ-021 Output buffering SHALL be a main register plus one skid register (2 entries total); output SHALL be in strict acceptance order with no loss or duplication.
REQ-022 src_ready_out SHALL be high iff the skid register is empty; it SHALL NOT depend combinationally on dst_ready_in.
REQ-023 dst_data_out SHALL stay stable while dst_valid_out is high and dst_ready_in is low.
REQ-024 With the main register full and dst_ready_in low, an accepted word SHALL go to the skid register and src_ready_out SHALL drop on the next cycle.
REQ-025 When the main register drains, the skid contents SHALL move to the main register in the same edge, and src_ready_out SHALL rise the following cycle.
REQ-026 Simultaneous output drain and input accept with the skid empty SHALL load the new word into the main register (full throughput, one word per cycle).
REQ-027 sat_count SHALL increment by 1 per accepted saturated word and hold at 16'hFFFF without wrap-around.
REQ-028 sat_clr SHALL zero sat_count and sat_flag; if it coincides with a saturation event, clear SHALL win and both SHALL read 0 next cycle.

Reset
REQ-029 While arst is high: src_ready_out=0, dst_valid_out=0, dst_data_out=0, sat_count=0, sat_flag=0, and both buffer entries empty.
REQ-030 After arst deasserts, src_ready_out SHALL be 1 from the first rising edge; reset mid-stream SHALL discard all buffered words.

Structure
REQ-031 Default widths and saturation limits SHALL be constants in the shared package pak_dsp_pkg.
REQ-032 The 2-entry elastic buffer SHALL be a sub-module named skid_buffer, parameterized on data width; rounding and saturation stay in fir_out_quantizer.

Verification
REQ-033 shift=4, inputs 24, 23, -24 -> outputs 2, 1, -1 on consecutive cycles, sat_count=0.
REQ-034 shift=0, inputs 40000 then -40000 -> 32767, -32768; sat_count=2; sat_flag=1.
REQ-035 dst_ready_in low, inputs 1, 2, 3 offered back-to-back (shift=0) -> 1 and 2 accepted, src_ready_out low in cycle 3; raising dst_ready_in -> outputs 1, 2, 3 in order.
REQ-036 sat_clr asserted in the same cycle as a saturated accept -> sat_count=0, sat_flag=0 next cycle.
REQ-037 arst pulsed with 2 words buffered -> dst_valid_out=0, no stale word after reset, src_ready_out=1 one edge later.
REQ-038 Continuous valid with dst_ready_in=1 for 100 words -> 100 outputs in 101 cycles and src_ready_out never low.

Source files
------------

// File: rtl/pak_dsp_pkg.sv
// Shared DSP constants: default FIR datapath widths and output saturation limits.
package pak_dsp_pkg;

  localparam int FIR_TAPS        = 29;
  localparam int SAMPLE_W        = 16;
  localparam int DEF_IN_WIDTH    = 2*SAMPLE_W + $clog2(FIR_TAPS);
  localparam int DEF_OUT_WIDTH   = 16;
  localparam int DEF_SHIFT_WIDTH = 5;
  localparam int DEF_SAT_MAX     = 32767;
  localparam int DEF_SAT_MIN     = -32768;
  localparam int SAT_CNT_W       = 16;

  // Two's-complement range limits for a w-bit signed result.
  function automatic int sat_hi(input int w);
    return (1 <<< (w-1)) - 1;
  endfunction

  function automatic int sat_lo(input int w);
    return -(1 <<< (w-1));
  endfunction

endpackage

// File: rtl/skid_buffer.sv
// Two-entry elastic buffer (main + skid) with a registered upstream ready.
module skid_buffer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         arst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  logic         m_vld, s_vld, rdy_q, s_vld_nxt;
  logic [W-1:0] m_data, s_data;
  logic         in_fire, m_open;

  assign in_fire   = in_valid & rdy_q;
  assign m_open    = ~m_vld | out_ready;
  // Skid only stays/becomes occupied while the main entry is stalled.
  assign s_vld_nxt = ~m_open & (s_vld | in_fire);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      m_vld  <= 1'b0;
      s_vld  <= 1'b0;
      rdy_q  <= 1'b0;
      m_data <= '0;
      s_data <= '0;
    end else begin
      rdy_q <= ~s_vld_nxt;
      s_vld <= s_vld_nxt;
      if (m_open) begin
        if (s_vld) begin
          m_data <= s_data;
          m_vld  <= 1'b1;
        end else if (in_fire) begin
          m_data <= in_data;
          m_vld  <= 1'b1;
        end else begin
          m_vld  <= 1'b0;
        end
      end else if (in_fire) begin
        s_data <= in_data;
      end
    end
  end

  assign in_ready  = rdy_q;
  assign out_data  = m_data;
  assign out_valid = m_vld;

endmodule

// File: rtl/fir_out_quantizer.sv
// Rounds (half-up), right-shifts and saturates a wide FIR result to an output sample.
module fir_out_quantizer
  import pak_dsp_pkg::*;
#(
  parameter int IN_WIDTH    = DEF_IN_WIDTH,
  parameter int OUT_WIDTH   = DEF_OUT_WIDTH,
  parameter int SHIFT_WIDTH = DEF_SHIFT_WIDTH
) (
  input  logic                        clk,
  input  logic                        arst,
  input  logic [SHIFT_WIDTH-1:0]      shift,
  input  logic                        sat_clr,
  input  logic signed [IN_WIDTH-1:0]  src_data_in,
  input  logic                        src_valid_in,
  output logic                        src_ready_out,
  output logic signed [OUT_WIDTH-1:0] dst_data_out,
  output logic                        dst_valid_out,
  input  logic                        dst_ready_in,
  output logic [SAT_CNT_W-1:0]        sat_count,
  output logic                        sat_flag
);

  localparam logic signed [IN_WIDTH:0] SAT_HI = (IN_WIDTH+1)'(sat_hi(OUT_WIDTH));
  localparam logic signed [IN_WIDTH:0] SAT_LO = (IN_WIDTH+1)'(sat_lo(OUT_WIDTH));

  logic signed [IN_WIDTH:0]  ext, rnd, sum, shd;
  logic                      is_hi, is_lo, in_fire;
  logic [OUT_WIDTH-1:0]      q, buf_out;

  // One extra bit of headroom so the rounding add cannot overflow.
  always_comb begin
    ext   = {src_data_in[IN_WIDTH-1], src_data_in};
    rnd   = (shift == '0) ? '0 : ({{IN_WIDTH{1'b0}}, 1'b1} << (shift - 1'b1));
    sum   = ext + rnd;
    shd   = sum >>> shift;
    is_hi = shd > SAT_HI;
    is_lo = shd < SAT_LO;
    if (is_hi)      q = SAT_HI[OUT_WIDTH-1:0];
    else if (is_lo) q = SAT_LO[OUT_WIDTH-1:0];
    else            q = shd[OUT_WIDTH-1:0];
  end

  assign in_fire = src_valid_in & src_ready_out;

  skid_buffer #(.W(OUT_WIDTH)) u_skid (
    .clk       (clk),
    .arst      (arst),
    .in_data   (q),
    .in_valid  (src_valid_in),
    .in_ready  (src_ready_out),
    .out_data  (buf_out),
    .out_valid (dst_valid_out),
    .out_ready (dst_ready_in)
  );

  assign dst_data_out = buf_out;

  // Clear beats a coincident saturation; the counter sticks at all-ones.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      sat_count <= '0;
      sat_flag  <= 1'b0;
    end else if (sat_clr) begin
      sat_count <= '0;
      sat_flag  <= 1'b0;
    end else if (in_fire && (is_hi || is_lo)) begin
      sat_flag <= 1'b1;
      if (sat_count != '1) sat_count <= sat_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_fir_out_quantizer.sv
// Directed self-checking bench for fir_out_quantizer.
module tb_fir_out_quantizer;

  logic               clk = 1'b0;
  logic               arst;
  logic [4:0]         shift;
  logic               sat_clr;
  logic signed [36:0] src_data_in;
  logic               src_valid_in;
  logic               src_ready_out;
  logic signed [15:0] dst_data_out;
  logic               dst_valid_out;
  logic               dst_ready_in;
  logic [15:0]        sat_count;
  logic               sat_flag;

  int checks = 0;
  int errors = 0;

  fir_out_quantizer dut (
    .clk           (clk),
    .arst          (arst),
    .shift         (shift),
    .sat_clr       (sat_clr),
    .src_data_in   (src_data_in),
    .src_valid_in  (src_valid_in),
    .src_ready_out (src_ready_out),
    .dst_data_out  (dst_data_out),
    .dst_valid_out (dst_valid_out),
    .dst_ready_in  (dst_ready_in),
    .sat_count     (sat_count),
    .sat_flag      (sat_flag)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    arst = 1'b1; shift = '0; sat_clr = 1'b0; src_data_in = '0;
    src_valid_in = 1'b0; dst_ready_in = 1'b0;
    step(); step();
    checks++;
    if ({src_ready_out, dst_valid_out, dst_data_out, sat_count, sat_flag} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%0b vld=%0b data=%0d cnt=%0d flag=%0b, want all 0",
               src_ready_out, dst_valid_out, dst_data_out, sat_count, sat_flag);
    end
    arst = 1'b0;
    step();
    checks++;
    if (src_ready_out !== 1'b1) begin
      errors++; $display("FAIL reset_ready_rise: got %0b want 1", src_ready_out);
    end
  endtask

  task automatic test_round();
    int inp [3] = '{24, 23, -24};
    int exp [3] = '{2, 1, -1};
    dst_ready_in = 1'b1; shift = 5'd4;
    for (int i = 0; i < 3; i++) begin
      src_valid_in = 1'b1; src_data_in = 37'(inp[i]);
      step();
      checks++;
      if (dst_valid_out !== 1'b1 || dst_data_out !== 16'(exp[i])) begin
        errors++;
        $display("FAIL round_%0d: vld=%0b data=%0d want vld=1 data=%0d",
                 i, dst_valid_out, dst_data_out, exp[i]);
      end
    end
    src_valid_in = 1'b0;
    step();
    checks++;
    if (dst_valid_out !== 1'b0 || sat_count !== 16'd0) begin
      errors++;
      $display("FAIL round_drain: vld=%0b cnt=%0d want 0 0", dst_valid_out, sat_count);
    end
  endtask

  task automatic test_sat();
    int inp [4] = '{40000, -40000, 32767, -32768};
    int exp [4] = '{32767, -32768, 32767, -32768};
    dst_ready_in = 1'b1; shift = 5'd0;
    for (int i = 0; i < 4; i++) begin
      src_valid_in = 1'b1; src_data_in = 37'(inp[i]);
      step();
      checks++;
      if (dst_valid_out !== 1'b1 || dst_data_out !== 16'(exp[i])) begin
        errors++;
        $display("FAIL sat_%0d: vld=%0b data=%0d want vld=1 data=%0d",
                 i, dst_valid_out, dst_data_out, exp[i]);
      end
    end
    src_valid_in = 1'b0;
    step();
    checks++;
    if (sat_count !== 16'd2 || sat_flag !== 1'b1) begin
      errors++;
      $display("FAIL sat_count: cnt=%0d flag=%0b want 2 1", sat_count, sat_flag);
    end
  endtask

  task automatic test_sat_clr();
    dst_ready_in = 1'b1; shift = 5'd0;
    src_valid_in = 1'b1; src_data_in = 37'sd50000; sat_clr = 1'b1;
    step();
    src_valid_in = 1'b0; sat_clr = 1'b0;
    checks++;
    if (sat_count !== 16'd0 || sat_flag !== 1'b0 || dst_data_out !== 16'sd32767) begin
      errors++;
      $display("FAIL sat_clr: cnt=%0d flag=%0b data=%0d want 0 0 32767",
               sat_count, sat_flag, dst_data_out);
    end
    step();
  endtask

  task automatic test_backpressure();
    dst_ready_in = 1'b0; shift = 5'd0;
    src_valid_in = 1'b1; src_data_in = 37'sd1;
    step();
    checks++;
    if (src_ready_out !== 1'b1 || dst_valid_out !== 1'b1 || dst_data_out !== 16'sd1) begin
      errors++;
      $display("FAIL bp_first: rdy=%0b vld=%0b data=%0d want 1 1 1",
               src_ready_out, dst_valid_out, dst_data_out);
    end
    src_data_in = 37'sd2;
    step();
    src_data_in = 37'sd3;
    checks++;
    if (src_ready_out !== 1'b0 || dst_data_out !== 16'sd1) begin
      errors++;
      $display("FAIL bp_full: rdy=%0b data=%0d want 0 1", src_ready_out, dst_data_out);
    end
    step();
    checks++;
    if (src_ready_out !== 1'b0 || dst_data_out !== 16'sd1) begin
      errors++;
      $display("FAIL bp_hold: rdy=%0b data=%0d want 0 1", src_ready_out, dst_data_out);
    end
    dst_ready_in = 1'b1;
    step();
    checks++;
    if (dst_valid_out !== 1'b1 || dst_data_out !== 16'sd2 || src_ready_out !== 1'b1) begin
      errors++;
      $display("FAIL bp_out2: vld=%0b data=%0d rdy=%0b want 1 2 1",
               dst_valid_out, dst_data_out, src_ready_out);
    end
    step();
    src_valid_in = 1'b0;
    checks++;
    if (dst_valid_out !== 1'b1 || dst_data_out !== 16'sd3) begin
      errors++;
      $display("FAIL bp_out3: vld=%0b data=%0d want 1 3", dst_valid_out, dst_data_out);
    end
    step();
    checks++;
    if (dst_valid_out !== 1'b0) begin
      errors++; $display("FAIL bp_empty: vld=%0b want 0", dst_valid_out);
    end
  endtask

  task automatic test_shift_hold();
    dst_ready_in = 1'b0; shift = 5'd4;
    src_valid_in = 1'b1; src_data_in = 37'sd48;
    step();
    src_valid_in = 1'b0; shift = 5'd0;
    step();
    checks++;
    if (dst_valid_out !== 1'b1 || dst_data_out !== 16'sd3) begin
      errors++;
      $display("FAIL shift_hold: vld=%0b data=%0d want 1 3", dst_valid_out, dst_data_out);
    end
    dst_ready_in = 1'b1;
    step();
  endtask

  task automatic test_reset_mid();
    dst_ready_in = 1'b0; shift = 5'd0;
    src_valid_in = 1'b1; src_data_in = 37'sd5;
    step();
    src_data_in = 37'sd6;
    step();
    src_valid_in = 1'b0;
    checks++;
    if (src_ready_out !== 1'b0 || dst_data_out !== 16'sd5) begin
      errors++;
      $display("FAIL rst_mid_fill: rdy=%0b data=%0d want 0 5", src_ready_out, dst_data_out);
    end
    arst = 1'b1;
    #1;
    checks++;
    if (dst_valid_out !== 1'b0 || src_ready_out !== 1'b0 || dst_data_out !== 16'sd0) begin
      errors++;
      $display("FAIL rst_mid_async: vld=%0b rdy=%0b data=%0d want 0 0 0",
               dst_valid_out, src_ready_out, dst_data_out);
    end
    step();
    arst = 1'b0; dst_ready_in = 1'b1;
    step();
    checks++;
    if (dst_valid_out !== 1'b0 || src_ready_out !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_after: vld=%0b rdy=%0b want 0 1", dst_valid_out, src_ready_out);
    end
    step();
    checks++;
    if (dst_valid_out !== 1'b0) begin
      errors++; $display("FAIL rst_mid_stale: vld=%0b want 0", dst_valid_out);
    end
  endtask

  task automatic test_back_to_back();
    int outs = 0;
    int rdy_low = 0;
    int bad = 0;
    int cyc = 0;
    dst_ready_in = 1'b1; shift = 5'd0;
    for (int i = 0; i < 100; i++) begin
      src_valid_in = 1'b1; src_data_in = 37'(i * 7 - 300);
      if (src_ready_out !== 1'b1) rdy_low++;
      step(); cyc++;
      if (dst_valid_out === 1'b1) begin
        outs++;
        if (dst_data_out !== 16'(i * 7 - 300)) bad++;
      end
    end
    src_valid_in = 1'b0;
    step(); cyc++;
    checks++;
    if (outs != 100 || bad != 0 || dst_valid_out !== 1'b0 || cyc != 101) begin
      errors++;
      $display("FAIL b2b_stream: outs=%0d bad=%0d vld_end=%0b want 100 0 0",
               outs, bad, dst_valid_out);
    end
    checks++;
    if (rdy_low != 0) begin
      errors++; $display("FAIL b2b_ready: low cycles=%0d want 0", rdy_low);
    end
  endtask

  initial begin
    test_reset();
    test_round();
    test_sat();
    test_sat_clr();
    test_backpressure();
    test_shift_hold();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
